// File: rtl/ps2_arrow_keys.sv
// rtl/ps2_arrow_keys.sv - PS/2 frame receiver and arrow/WASD held-direction decoder
module ps2_arrow_keys #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [3:0] btns,
  output logic [7:0] scan_code,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_SAT    = WD_W'(TIMEOUT_CYCLES);

  // CLK_HZ only documents the clock the timeout was sized for
  if (CLK_HZ <= 0 || FILTER_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("ps2_arrow_keys: invalid parameters");
  end

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;

  logic [1:0]        clk_sync, data_sync;
  logic              clk_s, data_s;
  logic              filt_level;
  logic [FILT_W-1:0] filt_cnt;
  logic              fe;

  frame_state_t      state, state_n;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_bit;
  logic [WD_W-1:0]   wd_cnt;
  logic              timeout, accept, ferr;

  logic              ext, brk;
  logic [3:0]        arrow_held, wasd_held;

  assign clk_s = clk_sync[1];
  assign data_s = data_sync[1];

  // Two-flop synchronizers; idle-high reset so release never looks like an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
    end
  end

  // Clock filter: level follows only after FILTER_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_level <= 1'b1;
      filt_cnt   <= '0;
      fe         <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s == filt_level) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_level <= clk_s;
        filt_cnt   <= '0;
        fe         <= ~clk_s;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign timeout = (state != IDLE) && !fe && (wd_cnt == WD_LAST);

  // Frame next-state, accept and error decode
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: if (fe && !data_s) state_n = DATA;
      DATA: begin
        if (timeout) begin
          state_n = IDLE;
          ferr    = 1'b1;
        end else if (fe && bit_cnt == 3'd7) begin
          state_n = PARITY;
        end
      end
      PARITY: begin
        if (timeout) begin
          state_n = IDLE;
          ferr    = 1'b1;
        end else if (fe) begin
          state_n = STOP;
        end
      end
      STOP: begin
        if (timeout) begin
          state_n = IDLE;
          ferr    = 1'b1;
        end else if (fe) begin
          state_n = IDLE;
          if (data_s && (^{shift, par_bit})) accept = 1'b1;
          else                               ferr   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Frame state, shift register, parity latch and watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state <= state_n;
      if (state_n == IDLE || fe) wd_cnt <= '0;
      else if (wd_cnt != WD_SAT) wd_cnt <= wd_cnt + 1'b1;
      case (state)
        IDLE:   if (fe) bit_cnt <= '0;
        DATA: begin
          if (fe) begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: if (fe) par_bit <= data_s;
        default: ;
      endcase
    end
  end

  // Registered output pulses and last accepted byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      scan_code <= '0;
    end else begin
      key_valid <= accept;
      frame_err <= ferr;
      if (accept) scan_code <= shift;
    end
  end

  // Code FSM: prefix flags and held bits for both key sources
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      arrow_held <= '0;
      wasd_held  <= '0;
    end else if (accept) begin
      if (shift == 8'hE0) begin
        ext <= 1'b1;
      end else if (shift == 8'hF0) begin
        brk <= 1'b1;
      end else if (shift == 8'hAA) begin
        ext        <= 1'b0;
        brk        <= 1'b0;
        arrow_held <= '0;
        wasd_held  <= '0;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (ext) begin
          case (shift)
            8'h75:   arrow_held[3] <= ~brk;
            8'h72:   arrow_held[2] <= ~brk;
            8'h74:   arrow_held[1] <= ~brk;
            8'h6B:   arrow_held[0] <= ~brk;
            default: ;
          endcase
        end else begin
          case (shift)
            8'h1D:   wasd_held[3] <= ~brk;
            8'h1B:   wasd_held[2] <= ~brk;
            8'h23:   wasd_held[1] <= ~brk;
            8'h1C:   wasd_held[0] <= ~brk;
            default: ;
          endcase
        end
      end
    end
  end

  assign btns = arrow_held | wasd_held;

endmodule
